crc_check: RTL and testbench
============================

CRC_CHECK -- requirements
Module: crc_check

Interface
REQ-001 Parameter width, default 32: message bits carried in the codeword.
REQ-002 Parameter poly_width, default 9: generator polynomial bits; CRC field is poly_width-1 bits.
REQ-003 Local constant N = width+poly_width-1: codeword length in bits.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to check the codeword presented in the same cycle.
REQ-007 codeword  input  N  message in bits [N-1:poly_width-1], CRC in bits [poly_width-2:0]; checked MSB first.
REQ-008 poly  input  poly_width  generator polynomial; bit poly_width-1 is ignored and treated as 1.
REQ-009 busy  output  1  high while a check is in progress.
REQ-010 done  output  1  one-cycle pulse; result outputs valid.
REQ-011 crc_ok  output  1  high when the last syndrome is zero.
REQ-012 syndrome  output  poly_width-1  remainder of codeword modulo poly over GF(2).
REQ-013 fail_count  output  16  count of completed checks with crc_ok=0; saturates at 16'hFFFF.

Function
REQ-014 FSM states IDLE, SHIFT and DONE; exactly one state active.
REQ-015 IDLE: start=1 at an edge latches codeword and poly, clears the remainder register and the bit counter, and enters SHIFT.
REQ-016 SHIFT: each edge consumes one codeword bit, MSB first, through a bit-serial LFSR division by the latched poly.
REQ-017 SHIFT lasts exactly N edges; the Nth edge enters DONE.
REQ-018 Latency: start sampled at edge E0 -> busy=1 after E0 through EN; done=1 for the cycle following EN.
REQ-019 syndrome and crc_ok update at the SHIFT->DONE edge.
REQ-020 syndrome and crc_ok hold their values until the next SHIFT->DONE edge or reset.
REQ-021 crc_ok = (syndrome == 0).
REQ-022 fail_count increments at the SHIFT->DONE edge when the new syndrome is nonzero, unless already 16'hFFFF.
REQ-023 DONE: start=1 behaves as in IDLE (back-to-back checks, no idle gap); otherwise the next edge enters IDLE.
REQ-024 start is ignored in SHIFT.
REQ-025 Changes on codeword or poly after acceptance do not affect the check in progress.
REQ-026 busy=1 only in SHIFT; done=1 only in DONE.
REQ-027 Result definition: syndrome equals the remainder from dividing codeword by poly MSB first, with the remainder register initialised to zero.
REQ-028 Consequence of REQ-027: a codeword built as {message, remainder of message·x^(poly_width-1) mod poly} yields syndrome 0.

Reset
REQ-029 reset=1 at an edge forces IDLE from any state and clears the remainder register and the bit counter.
REQ-030 Reset values: busy=0, done=0, crc_ok=0, syndrome=0, fail_count=0.
REQ-031 reset has priority over start; start in the same cycle as reset is dropped.
REQ-032 reset during SHIFT aborts the check: no done pulse, and fail_count is unchanged from its reset value.

Verification (width=32, poly_width=9, poly=9'h107)
REQ-033 codeword=40'h0000000107, start for one cycle -> busy high for 40 cycles, then done=1, syndrome=8'h00, crc_ok=1, fail_count=0.
REQ-034 codeword=40'h0000000100 -> syndrome=8'h07, crc_ok=0, fail_count=1.
REQ-035 codeword=40'h0000000001 -> syndrome=8'h01; codeword all-zero -> syndrome=8'h00, crc_ok=1.
REQ-036 start held high across two checks -> second check begins in the DONE cycle and completes 41 cycles after the first done; codeword changes mid-SHIFT do not affect the result.
REQ-037 reset asserted at SHIFT cycle 20 together with start -> next cycle busy=0, done=0, syndrome=0, fail_count=0, and no done pulse follows.
REQ-038 Force fail_count to 16'hFFFF, then run a failing check -> fail_count stays 16'hFFFF.

Source files
------------

// File: rtl/crc_check.sv
// Bit-serial CRC checker: divides a latched codeword by a latched generator
// polynomial MSB first and reports the remainder, a pass flag and a failure count.
module crc_check #(
  parameter int width      = 32,
  parameter int poly_width = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [width+poly_width-2:0] codeword,
  input  logic [poly_width-1:0]       poly,
  output logic                        busy,
  output logic                        done,
  output logic                        crc_ok,
  output logic [poly_width-2:0]       syndrome,
  output logic [15:0]                 fail_count,
  output logic [1:0]                  state_dbg
);

  localparam int N  = width + poly_width - 1;
  localparam int RW = poly_width - 1;
  localparam int CW = $clog2(N + 1);

  // Handshake: start is a request sampled only in IDLE or DONE; done is a
  // one-cycle pulse marking syndrome/crc_ok/fail_count as freshly valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  shreg_q;
  logic [RW-1:0] poly_q;
  logic [RW-1:0] rem_q;
  logic [RW-1:0] rem_next;
  logic [CW-1:0] cnt_q;
  logic          accept;
  logic          last;

  // The polynomial's leading term is implied, so its input bit is never used.
  logic unused_poly_msb;
  assign unused_poly_msb = poly[poly_width-1];

  // One LFSR step: shift in the next codeword bit, reduce when x^RW falls out.
  assign rem_next = {rem_q[RW-2:0], shreg_q[N-1]} ^ (rem_q[RW-1] ? poly_q : '0);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CW'(N - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == SHIFT);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      cnt_q      <= '0;
      syndrome   <= '0;
      crc_ok     <= 1'b0;
      fail_count <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rem_q <= '0;
        cnt_q <= '0;
      end else if (busy) begin
        rem_q <= rem_next;
        cnt_q <= cnt_q + CW'(1);
      end
      if (last) begin
        syndrome <= rem_next;
        crc_ok   <= (rem_next == '0);
        if ((rem_next != '0) && (fail_count != 16'hFFFF)) begin
          fail_count <= fail_count + 16'd1;
        end
      end
    end
  end

  // Operand capture needs no reset: it is always loaded before it is consumed.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      shreg_q <= codeword;
      poly_q  <= poly[RW-1:0];
    end else if (busy) begin
      shreg_q <= {shreg_q[N-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_crc_check.sv
// Self-checking bench for crc_check: long-division reference model, randomized
// codewords, back-to-back checks, mid-check reset and fail-count saturation.
module tb_crc_check;

  localparam int W  = 32;
  localparam int PW = 9;
  localparam int N  = W + PW - 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic [N-1:0]  codeword;
  logic [PW-1:0] poly;
  logic          busy;
  logic          done;
  logic          crc_ok;
  logic [PW-2:0] syndrome;
  logic [15:0]   fail_count;
  logic [1:0]    state_dbg;

  int vectors;
  int miscompares;
  logic [PW-2:0] exp_q[$];
  logic [15:0]   exp_fail;

  crc_check #(.width(W), .poly_width(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .codeword   (codeword),
    .poly       (poly),
    .busy       (busy),
    .done       (done),
    .crc_ok     (crc_ok),
    .syndrome   (syndrome),
    .fail_count (fail_count),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Schoolbook GF(2) long division; the polynomial's top bit is forced to 1.
  function automatic logic [PW-2:0] model_rem(input logic [N-1:0] cw, input logic [PW-1:0] p);
    logic [N-1:0] r;
    logic [N-1:0] g;
    r = cw;
    g = N'({1'b1, p[PW-2:0]});
    for (int i = N - 1; i >= PW - 1; i--) begin
      if (r[i]) r = r ^ (g << (i - (PW - 1)));
    end
    return r[PW-2:0];
  endfunction

  function automatic logic [N-1:0] make_valid(input logic [W-1:0] msg, input logic [PW-1:0] p);
    return {msg, model_rem({msg, {(PW-1){1'b0}}}, p)};
  endfunction

  function automatic logic [15:0] next_fail(input logic [15:0] cnt, input logic [PW-2:0] syn);
    if (syn != '0 && cnt != 16'hFFFF) return cnt + 16'd1;
    return cnt;
  endfunction

  // ---------------- driver tasks ----------------
  // One full check: start for one cycle, then scramble inputs while it runs.
  task automatic run_check(input logic [N-1:0] cw, input logic [PW-1:0] p, input string name);
    int cycles;
    logic [PW-2:0] exp;
    @(negedge clk);
    codeword = cw;
    poly     = p;
    start    = 1'b1;
    exp_q.push_back(model_rem(cw, p));
    @(negedge clk);
    start    = 1'b0;
    codeword = N'({$urandom(), $urandom()});
    poly     = PW'($urandom());
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    exp_fail = next_fail(exp_fail, exp);
    vectors++;
    if (cycles !== N) begin
      miscompares++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, cycles, N);
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s done: got %b expected 1", name, done);
    end
    vectors++;
    if (syndrome !== exp) begin
      miscompares++;
      $display("FAIL %s syndrome: got %h expected %h", name, syndrome, exp);
    end
    vectors++;
    if (crc_ok !== (exp == '0)) begin
      miscompares++;
      $display("FAIL %s crc_ok: got %b expected %b", name, crc_ok, (exp == '0));
    end
    vectors++;
    if (fail_count !== exp_fail) begin
      miscompares++;
      $display("FAIL %s fail_count: got %h expected %h", name, fail_count, exp_fail);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    codeword = '0;
    poly = 9'h107;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_fail = 16'h0000;
    @(negedge clk);
    vectors++;
    if ({busy, done, crc_ok, syndrome, fail_count, state_dbg} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: got busy=%b done=%b ok=%b syn=%h fc=%h st=%0d expected all 0",
               busy, done, crc_ok, syndrome, fail_count, state_dbg);
    end
  endtask

  task automatic test_known_vectors();
    run_check(40'h0000000107, 9'h107, "poly_itself");
    run_check(40'h0000000100, 9'h107, "x8");
    run_check(40'h0000000001, 9'h107, "one");
    run_check(40'h0000000000, 9'h107, "zero");
    // Leading poly bit is implied, so 9'h007 divides exactly like 9'h107.
    run_check(40'h0000000100, 9'h007, "poly_msb_ignored");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0]  msg;
      logic [PW-1:0] p;
      logic [N-1:0]  cw;
      msg = $urandom();
      p   = PW'($urandom_range(0, 511));
      if (i % 2 == 0) cw = make_valid(msg, p);
      else            cw = N'({$urandom(), $urandom()});
      run_check(cw, p, (i % 2 == 0) ? "random_valid" : "random_any");
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] cw_a;
    logic [N-1:0] cw_b;
    logic [PW-2:0] exp;
    int n;
    cw_a = N'({$urandom(), $urandom()});
    cw_b = make_valid($urandom(), 9'h107);
    @(negedge clk);
    codeword = cw_a;
    poly     = 9'h107;
    start    = 1'b1;
    exp_q.push_back(model_rem(cw_a, 9'h107));
    exp_q.push_back(model_rem(cw_b, 9'h107));
    @(negedge clk);
    codeword = cw_b;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    exp_fail = next_fail(exp_fail, exp);
    vectors++;
    if (done !== 1'b1 || syndrome !== exp || fail_count !== exp_fail) begin
      miscompares++;
      $display("FAIL b2b_first: got done=%b syn=%h fc=%h expected 1 %h %h",
               done, syndrome, fail_count, exp, exp_fail);
    end
    @(negedge clk);
    start    = 1'b0;
    codeword = N'({$urandom(), $urandom()});
    n = 1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_restart: got busy=%b expected 1", busy);
    end
    while (done !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    exp_fail = next_fail(exp_fail, exp);
    vectors++;
    if (n !== N + 1) begin
      miscompares++;
      $display("FAIL b2b_gap: got %0d expected %0d", n, N + 1);
    end
    vectors++;
    if (syndrome !== exp || crc_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second: got syn=%h ok=%b expected %h 1", syndrome, crc_ok, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    bit seen_done;
    @(negedge clk);
    codeword = N'({$urandom(), $urandom()});
    poly     = 9'h107;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    exp_fail = 16'h0000;
    exp_q.delete();
    vectors++;
    if ({busy, done, crc_ok, syndrome, fail_count, state_dbg} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_shift: got busy=%b done=%b ok=%b syn=%h fc=%h st=%0d expected all 0",
               busy, done, crc_ok, syndrome, fail_count, state_dbg);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done) begin
      miscompares++;
      $display("FAIL reset_abort: got activity=1 expected 0");
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    force dut.fail_count = 16'hFFFF;
    @(negedge clk);
    release dut.fail_count;
    exp_fail = 16'hFFFF;
    run_check(40'h0000000100, 9'h107, "saturate");
    run_check(40'h0000000001, 9'h107, "saturate_again");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    exp_fail = 16'h0000;
    test_reset();
    test_known_vectors();
    test_random();
    test_back_to_back();
    run_check(40'h0000000100, 9'h107, "pre_reset_fail");
    test_reset_mid_shift();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
